mix_columns_seq: RTL
====================

# mix_columns_seq

Column-serial AES MixColumns stage sitting directly downstream of `shiftRows` in the cipher round datapath. It accepts one full AES state per valid/ready handshake and transforms one column per clock using a single GF(2^8) column unit. It presents the result to the AddRoundKey stage through a second valid/ready handshake. A final-round flag passes the state through unchanged with identical timing, so round control never needs to special-case latency.

## Interface
- No parameters. Geometry is fixed by `t_opaque_AESState`: 4 columns × 4 bytes, indexed `state[col][row]`, 128 bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: upstream (`shiftRows` output) holds a valid state.
- `in_ready` out 1: stage can accept; the handshake fires on `in_valid & in_ready` at a rising edge.
- `in_state` in 128 (`t_opaque_AESState`): state to transform; sampled only at acceptance.
- `in_last` in 1: final AES round; when set, MixColumns is bypassed. Sampled with `in_state`.
- `out_valid` out 1: `out_state` is valid.
- `out_ready` in 1: downstream accepts; the transfer fires on `out_valid & out_ready`.
- `out_state` out 128 (`t_opaque_AESState`): transformed state.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - BUSY: column counter `col` runs 0..3.
  - DONE: `out_valid`=1.
- IDLE → BUSY on acceptance. The edge loads `in_state` into the working register, latches `in_last`, and sets `col`=0.
- BUSY: each edge replaces working column `col` with its transformed value and increments `col`. After the edge that writes column 3, the FSM goes to DONE. `col` wraps to 0 and is unused outside BUSY.
- DONE: the working register drives `out_state`.
  - If `out_valid & out_ready` and `in_valid`: accept the new state on the same edge (next state BUSY, no bubble).
  - If `out_valid & out_ready` only: go to IDLE.
  - Otherwise hold, with `out_state` bit-stable.
- `in_ready` = (IDLE) | (DONE & `out_ready`). It is combinational from state and `out_ready`, and forced 0 while `rst` is low.
- `in_valid` while in BUSY is ignored and never captured. Upstream must hold it per handshake rules.
- Column transform on bytes a0..a3 (rows 0..3). Define xtime(b) = {b[6:0],0} XOR (b[7] ? 0x1B : 0x00). All arithmetic is 8-bit XOR; there is no carry or overflow.
  - r0 = 2a0^3a1^a2^a3
  - r1 = a0^2a1^3a2^a3
  - r2 = a0^a1^2a2^3a3
  - r3 = 3a0^a1^a2^2a3
  - 2x = xtime(x), 3x = xtime(x)^x.
- Bypass (`in_last`=1 latched): each BUSY edge rewrites column `col` with itself. Timing is identical to the normal path.

## Timing
- Reset (`rst` low, asynchronous): FSM=IDLE, `col`=0, working register=0, latched last=0, `out_valid`=0, `out_state`=0, `in_ready`=0. After deassertion the FSM is IDLE and `in_ready`=1.
- Reset mid-operation (BUSY or DONE) aborts immediately. The partial state is discarded and no `out_valid` pulse occurs.
- Latency: acceptance edge E0; column edges E1..E4; `out_valid`=1 in the cycle following E4. That is 4 cycles from acceptance to `out_valid`, regardless of `in_last`.
- Throughput with `out_ready` held at 1: one state per 5 cycles, back-to-back via the DONE-accept path.
- `out_valid` never drops without a completed transfer, except on reset.

## Test plan
- FIPS-197 round 1 vector:
  - Stimulus: `in_state` bytes (col-major) d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5, `in_last`=0, `out_ready`=1.
  - Required: `out_state` 04 66 81 e5 e0 cb 19 9a 48 f8 d3 7a 28 06 26 4c, with `out_valid` exactly 4 cycles after acceptance.
- Single-column vectors, all four columns set in turn:
  - db 13 53 45 → 8e 4d a1 bc
  - f2 0a 22 5c → 9f dc 58 9d
  - 01 01 01 01 → unchanged
  - c6 c6 c6 c6 → unchanged
  - d4 d4 d4 d5 → d5 d5 d7 d6
- Bypass: the round 1 input with `in_last`=1 → `out_state` equals input bit-exactly, same 4-cycle latency.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`.
  - `out_state` stable and `in_ready`=0 throughout; `in_valid` pulses during BUSY are not captured.
  - Releasing `out_ready` with `in_valid`=1 transfers the output and accepts the next state on the same edge.
- Reset mid-BUSY: assert `rst` after E2.
  - Outputs zero immediately with `out_valid`=0.
  - After release, the round 1 vector produces the correct result.
- Random stream: 200 random states with random `in_valid`/`out_ready` gaps, checked against a software MixColumns model. There must be no drops, duplicates, or reorders.

Source files
------------

// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns stage: one state per handshake, one column per clock,
// with a final-round bypass of identical latency. Byte (col,row) sits at bits [127-8*(4*col+row) -: 8].
module mix_columns_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] work_q;
  logic         last_q;
  logic [1:0]   col_q;
  logic         accept;
  logic [31:0]  col_in;
  logic [31:0]  col_new;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column word is {row0, row1, row2, row3}, row 0 in the top byte.
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

  // Held in reset, the stage must not advertise readiness even though it sits in IDLE.
  assign in_ready  = rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign out_state = work_q;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    col_in = work_q[127:96];
    unique case (col_q)
      2'd0: col_in = work_q[127:96];
      2'd1: col_in = work_q[95:64];
      2'd2: col_in = work_q[63:32];
      2'd3: col_in = work_q[31:0];
    endcase
  end

  // The bypass rewrites the column with itself so the final round keeps the same timing.
  assign col_new = last_q ? col_in : mix_column(col_in);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: if (col_q == 2'd3) state_d = DONE;
      DONE: begin
        if (out_ready) state_d = in_valid ? BUSY : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the working register is reset too, because it drives out_state directly and must read zero in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      last_q  <= 1'b0;
      col_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        work_q <= in_state;
        last_q <= in_last;
        col_q  <= 2'd0;
      end else if (state_q == BUSY) begin
        unique case (col_q)
          2'd0: work_q[127:96] <= col_new;
          2'd1: work_q[95:64]  <= col_new;
          2'd2: work_q[63:32]  <= col_new;
          2'd3: work_q[31:0]   <= col_new;
        endcase
        col_q <= col_q + 2'd1;
      end
    end
  end

endmodule
